// File: rtl/alu_sequencer.sv
// alu_sequencer: control FSM for the 4-bit operand / 8-bit result datapath.
// Takes one opcode per start/done handshake. It drives the A/B/O load strobes,
// the shift register controls and the O-input mux select. It sequences
// shift-by-N and a MUL_STEPS-step shift-add multiply.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; latches opcode/shamt when start arrives
// EXEC    | single-cycle register action (LDA, LDB, or LDO with A+B)
// SHLOAD  | shift register loadEnable pulse
// SHIFT   | shiftState held for shamt cycles; down-counter times the run
// WB      | write shifter output into O
// MCLR    | clear O before the multiply
// MSTEP   | one shift-add step per cycle; LDO gated by multBit
// DONE    | one-cycle done pulse (errOp for the illegal opcode)
module alu_sequencer #(
  parameter int COUNT_WIDTH = 3,
  parameter int MUL_STEPS   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             opcode,
  input  logic [COUNT_WIDTH-1:0] shamt,
  input  logic                   rshFlag,
  input  logic                   multBit,
  output logic                   busy,
  output logic                   done,
  output logic                   errOp,
  output logic                   underflow,
  output logic                   LDA,
  output logic                   LDB,
  output logic                   LDO,
  output logic                   shLoad,
  output logic [1:0]             shiftState,
  output logic [1:0]             oSel,
  output logic [COUNT_WIDTH-1:0] stepIdx
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_LDB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_LSH = 3'b100;
  localparam logic [2:0] OP_RSH = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [1:0] SEL_SHIFT = 2'b00;
  localparam logic [1:0] SEL_ADD   = 2'b01;
  localparam logic [1:0] SEL_MACC  = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;

  localparam logic [1:0] SH_LEFT  = 2'b10;
  localparam logic [1:0] SH_RIGHT = 2'b01;
  localparam logic [1:0] SH_HOLD  = 2'b00;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] STEP_LAST = COUNT_WIDTH'(MUL_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SHLOAD,
    S_SHIFT,
    S_WB,
    S_MCLR,
    S_MSTEP,
    S_DONE
  } state_t;

  state_t                 state;
  logic [2:0]             op_q;
  logic [COUNT_WIDTH-1:0] shamt_q;
  logic [COUNT_WIDTH-1:0] shift_cnt;
  logic                   shift_first;
  logic                   ldo_q;
  logic                   mstep_q;
  logic [1:0]             shift_dir;

  assign shift_dir = (op_q == OP_LSH) ? SH_LEFT : SH_RIGHT;

  // During a multiply step the O load depends on the B bit that the datapath
  // selects with the current stepIdx, so that one strobe is gated by multBit
  // in the same cycle. Every other LDO pulse comes straight from a register.
  assign LDO = ldo_q | (mstep_q & multBit);

  // Sequencer state, latched operands and registered outputs. Each branch
  // sets the outputs for the state it moves into.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      shamt_q     <= '0;
      shift_cnt   <= '0;
      shift_first <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      errOp       <= 1'b0;
      underflow   <= 1'b0;
      LDA         <= 1'b0;
      LDB         <= 1'b0;
      ldo_q       <= 1'b0;
      mstep_q     <= 1'b0;
      shLoad      <= 1'b0;
      shiftState  <= SH_HOLD;
      oSel        <= SEL_SHIFT;
      stepIdx     <= '0;
    end else begin
      busy       <= 1'b0;
      done       <= 1'b0;
      errOp      <= 1'b0;
      LDA        <= 1'b0;
      LDB        <= 1'b0;
      ldo_q      <= 1'b0;
      mstep_q    <= 1'b0;
      shLoad     <= 1'b0;
      shiftState <= SH_HOLD;
      oSel       <= SEL_SHIFT;
      stepIdx    <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            op_q      <= opcode;
            shamt_q   <= shamt;
            underflow <= 1'b0;
            case (opcode)
              OP_NOP: begin
                state <= S_DONE;
                done  <= 1'b1;
              end
              OP_LDA: begin
                state <= S_EXEC;
                busy  <= 1'b1;
                LDA   <= 1'b1;
              end
              OP_LDB: begin
                state <= S_EXEC;
                busy  <= 1'b1;
                LDB   <= 1'b1;
              end
              OP_ADD: begin
                state <= S_EXEC;
                busy  <= 1'b1;
                ldo_q <= 1'b1;
                oSel  <= SEL_ADD;
              end
              OP_LSH, OP_RSH: begin
                state  <= S_SHLOAD;
                busy   <= 1'b1;
                shLoad <= 1'b1;
              end
              OP_MUL: begin
                state <= S_MCLR;
                busy  <= 1'b1;
                ldo_q <= 1'b1;
                oSel  <= SEL_ZERO;
              end
              default: begin
                state <= S_DONE;
                done  <= 1'b1;
                errOp <= 1'b1;
              end
            endcase
          end
        end

        S_EXEC: begin
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_SHLOAD: begin
          busy <= 1'b1;
          if (shamt_q != '0) begin
            state       <= S_SHIFT;
            shiftState  <= shift_dir;
            shift_cnt   <= shamt_q - CNT_ONE;
            shift_first <= 1'b1;
          end else begin
            state <= S_WB;
            ldo_q <= 1'b1;
            oSel  <= SEL_SHIFT;
          end
        end

        S_SHIFT: begin
          busy        <= 1'b1;
          shift_first <= 1'b0;
          // The shifter flag is only meaningful once a shift has happened.
          if ((op_q == OP_RSH) && !shift_first && rshFlag) begin
            underflow <= 1'b1;
          end
          if (shift_cnt == '0) begin
            state <= S_WB;
            ldo_q <= 1'b1;
            oSel  <= SEL_SHIFT;
          end else begin
            shift_cnt  <= shift_cnt - CNT_ONE;
            shiftState <= shift_dir;
          end
        end

        S_WB: begin
          if ((op_q == OP_RSH) && rshFlag) begin
            underflow <= 1'b1;
          end
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_MCLR: begin
          state   <= S_MSTEP;
          busy    <= 1'b1;
          mstep_q <= 1'b1;
          oSel    <= SEL_MACC;
          stepIdx <= '0;
        end

        S_MSTEP: begin
          if (stepIdx == STEP_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            busy    <= 1'b1;
            mstep_q <= 1'b1;
            oSel    <= SEL_MACC;
            stepIdx <= stepIdx + CNT_ONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer. A cycle-indexed reference derived from the
// operation timing rules, a table of directed operations, hand-written
// corner sequences, and a random run.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] opcode;
  logic [2:0] shamt;
  logic       rshFlag;
  logic       multBit;
  logic       busy, done, errOp, underflow, LDA, LDB, LDO, shLoad;
  logic [1:0] shiftState, oSel;
  logic [2:0] stepIdx;

  logic [7:0] bpat = 8'h00;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.COUNT_WIDTH(3), .MUL_STEPS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .shamt(shamt),
    .rshFlag(rshFlag), .multBit(multBit), .busy(busy), .done(done),
    .errOp(errOp), .underflow(underflow), .LDA(LDA), .LDB(LDB), .LDO(LDO),
    .shLoad(shLoad), .shiftState(shiftState), .oSel(oSel), .stepIdx(stepIdx)
  );

  always #5 clk = ~clk;

  // datapath mux: B[stepIdx]
  always_comb multBit = bpat[stepIdx];

  function automatic logic [14:0] actual();
    return {busy, done, errOp, underflow, LDA, LDB, LDO, shLoad, shiftState, oSel, stepIdx};
  endfunction

  function automatic int op_lat(input logic [2:0] op, input logic [2:0] sh);
    case (op)
      3'd0, 3'd7:       return 1;
      3'd1, 3'd2, 3'd3: return 2;
      3'd4, 3'd5:       return int'(sh) + 3;
      default:          return 6;
    endcase
  endfunction

  // Expected outputs in cycle c (c=1 is the cycle after the start edge).
  function automatic logic [14:0] model(input logic [2:0] op, input logic [2:0] sh,
                                        input logic [7:0] bp, input logic [15:0] rsh,
                                        input int c);
    logic bz, dn, er, uf, la, lb, lo, sl;
    logic [1:0] ss, os;
    logic [2:0] si;
    int lat, shn, lo_k;
    bz = 0; dn = 0; er = 0; uf = 0; la = 0; lb = 0; lo = 0; sl = 0;
    ss = 2'b00; os = 2'b00; si = 3'd0;
    lat = op_lat(op, sh);
    shn = int'(sh);
    dn = (c == lat);
    er = dn && (op == 3'd7);
    bz = (c >= 1) && (c < lat);
    case (op)
      3'd1: la = (c == 1);
      3'd2: lb = (c == 1);
      3'd3: if (c == 1) begin lo = 1; os = 2'b01; end
      3'd4, 3'd5: begin
        if (c == 1) sl = 1;
        if (c >= 2 && c <= shn + 1) ss = (op == 3'd4) ? 2'b10 : 2'b01;
        if (c == shn + 2) begin lo = 1; os = 2'b00; end
      end
      3'd6: begin
        if (c == 1) begin lo = 1; os = 2'b11; end
        if (c >= 2 && c <= 5) begin
          si = 3'(c - 2);
          os = 2'b10;
          lo = bp[c-2];
        end
      end
      default: ;
    endcase
    if (op == 3'd5) begin
      lo_k = (shn == 0) ? 2 : 3;
      for (int k = lo_k; k <= shn + 2; k++)
        if (k < c && rsh[k]) uf = 1;
    end
    return {bz, dn, er, uf, la, lb, lo, sl, ss, os, si};
  endfunction

  task automatic check(input string name, input int c, input logic [14:0] got,
                       input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h exp %h", name, c, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // Issue one op with a start pulse, compare every cycle up to the IDLE cycle
  // after done. With hold set, start stays high and opcode switches to LDA.
  task automatic run_op(input string name, input logic [2:0] op, input logic [2:0] sh,
                        input logic [7:0] bp, input logic [15:0] rsh, input bit hold,
                        input int exp_lat, input int exp_uf);
    int lat;
    int seen;
    lat  = op_lat(op, sh);
    seen = -1;
    @(negedge clk);
    bpat = bp; opcode = op; shamt = sh; start = 1'b1; rshFlag = rsh[0];
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      start = hold;
      if (hold) begin
        opcode = 3'b001;
        shamt  = 3'($urandom);
      end else begin
        opcode = 3'($urandom);
        shamt  = 3'($urandom);
      end
      rshFlag = rsh[c];
      check(name, c, actual(), model(op, sh, bp, rsh, c));
      if (done && seen < 0) seen = c;
    end
    check_int({name, "_lat"}, seen, exp_lat);
    if (exp_uf >= 0) check_int({name, "_uf"}, int'(underflow), exp_uf);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  sh;
    logic [7:0]  bp;
    logic [15:0] rsh;
    int          lat;
    int          uf;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{3'd1, 3'd0, 8'h00, 16'h0000, 2, 0};
    tbl[1]  = '{3'd3, 3'd0, 8'h00, 16'h0000, 2, 0};
    tbl[2]  = '{3'd5, 3'd3, 8'h00, 16'h0008, 6, 1};
    tbl[3]  = '{3'd4, 3'd0, 8'h00, 16'h0000, 3, 0};
    tbl[4]  = '{3'd6, 3'd0, 8'h0D, 16'h0000, 6, 0};
    tbl[5]  = '{3'd7, 3'd0, 8'h00, 16'h0000, 1, 0};
    tbl[6]  = '{3'd0, 3'd0, 8'h00, 16'h0000, 1, 0};
    tbl[7]  = '{3'd2, 3'd0, 8'h00, 16'h0000, 2, 0};
    tbl[8]  = '{3'd5, 3'd7, 8'h00, 16'h0004, 10, 0};
    tbl[9]  = '{3'd5, 3'd0, 8'h00, 16'h0004, 3, 1};
    tbl[10] = '{3'd4, 3'd5, 8'h00, 16'hFFFF, 8, 0};
    tbl[11] = '{3'd5, 3'd2, 8'h00, 16'h0010, 5, 1};
    tbl[12] = '{3'd5, 3'd2, 8'h00, 16'h0020, 5, 0};
    tbl[13] = '{3'd6, 3'd0, 8'h0F, 16'h0000, 6, 0};

    reset = 1'b1; start = 1'b0; opcode = 3'd0; shamt = 3'd0; rshFlag = 1'b0;
    #1 reset = 1'b0;
    #2 check("reset", 0, actual(), 15'h0000);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].sh, tbl[i].bp, tbl[i].rsh,
             1'b0, tbl[i].lat, tbl[i].uf);

    // underflow set by an RSH stays through idle cycles
    run_op("rsh_sticky", 3'd5, 3'd1, 8'h00, 16'h0008, 1'b0, 4, 1);
    repeat (3) @(negedge clk);
    check_int("uf_idle", int'(underflow), 1);

    // start held through a MUL with opcode changed to LDA: MUL unaffected,
    // then the held start is taken in the first IDLE cycle
    run_op("mul_hold", 3'd6, 3'd0, 8'h05, 16'h0000, 1'b1, 6, 0);
    @(negedge clk);
    start = 1'b0;
    check("hold_lda", 1, actual(), model(3'd1, 3'd0, 8'h00, 16'h0000, 1));
    @(negedge clk);
    check("hold_lda", 2, actual(), model(3'd1, 3'd0, 8'h00, 16'h0000, 2));

    // reset in SHIFT cycle 2 of an LSH by 5
    @(negedge clk);
    opcode = 3'd4; shamt = 3'd5; start = 1'b1; rshFlag = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_shift", 3, actual(), model(3'd4, 3'd5, 8'h00, 16'h0000, 3));
    #2 reset = 1'b0;
    #1 check("async_rst", 0, actual(), 15'h0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_hold", c, actual(), 15'h0000);
    end
    reset = 1'b1;
    run_op("ldb_after_rst", 3'd2, 3'd0, 8'h00, 16'h0000, 1'b0, 2, 0);

    // random operations against the reference
    for (int n = 0; n < 80; n++) begin
      logic [2:0]  rop, rsh_amt;
      logic [7:0]  rbp;
      logic [15:0] rrsh;
      rop     = 3'($urandom_range(0, 7));
      rsh_amt = 3'($urandom);
      rbp     = 8'($urandom);
      rrsh    = 16'($urandom);
      run_op("rand", rop, rsh_amt, rbp, rrsh, 1'b0, op_lat(rop, rsh_amt), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
